// File: rtl/banked_ram_ctrl.sv
// banked_ram_ctrl: single-clock RAM with byte-enable writes, 1/2-cycle reads,
// selectable read-during-write result and a built-in clear engine.
module banked_ram_ctrl #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   wa,
    input  logic [DATA_WIDTH-1:0]   di,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   ra,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_IDLE  = 1'b1;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("banked_ram_ctrl: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("banked_ram_ctrl: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("banked_ram_ctrl: DEPTH exceeds 2**ADDR_WIDTH");
    end

    logic [0:0]            state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] d1;
    logic                  v1;

    assign busy  = state == S_CLEAR;
    assign wr_en = !busy && we && ({1'b0, wa} < DEPTH_W);
    assign rd_en = !busy && re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else if (state == S_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == DEPTH_W - 1'b1) state <= S_IDLE;
        end else if (clr) begin
            cnt   <= '0;
            state <= S_CLEAR;
        end
    end

    // Array has no reset; the clear engine is the only way it gets zeroed.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            ram[cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NB; k++)
                if (be[k]) ram[wa][8*k +: 8] <= di[8*k +: 8];
        end
    end

    always_comb begin
        rd_word = ({1'b0, ra} < DEPTH_W) ? ram[ra] : '0;
        for (int k = 0; k < NB; k++)
            if (RDW_MODE == 1 && wr_en && wa == ra && be[k]) rd_word[8*k +: 8] = di[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_en;
            if (rd_en) d1 <= rd_word;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] d2;
        logic                  v2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d2 <= '0;
                v2 <= 1'b0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end
        assign dout       = d2;
        assign dout_valid = v2;
    end else begin : g_lat1
        assign dout       = d1;
        assign dout_valid = v1;
    end
endmodule

// File: tb/tb_banked_ram_ctrl.sv
// tb_banked_ram_ctrl: scoreboard bench driving two configurations in lockstep:
// u0 = defaults (AW 9, latency 1, old-data RDW), u1 = AW 10, latency 2, new-data RDW.
module tb_banked_ram_ctrl;
    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [9:0]  wa = '0;
    logic [9:0]  ra = '0;
    logic [15:0] di = '0;
    logic        busy [2];
    logic        dv [2];
    logic [15:0] dout [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    banked_ram_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy[0]), .we(we), .be(be),
        .wa(wa[8:0]), .di(di), .re(re), .ra(ra[8:0]), .dout(dout[0]), .dout_valid(dv[0])
    );

    banked_ram_ctrl #(.ADDR_WIDTH(10), .DEPTH(512), .READ_LATENCY(2), .RDW_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy[1]), .we(we), .be(be),
        .wa(wa), .di(di), .re(re), .ra(ra), .dout(dout[1]), .dout_valid(dv[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (dv[0]) begin
            if (q0.size() == 0) chk("u0 unexpected dout_valid", 1, 0);
            else begin
                e = q0.pop_front();
                chk("u0 dout", int'(dout[0]), int'(e.d));
                chk("u0 latency", cyc, e.c);
            end
        end
        if (dv[1]) begin
            if (q1.size() == 0) chk("u1 unexpected dout_valid", 1, 0);
            else begin
                e = q1.pop_front();
                chk("u1 dout", int'(dout[1]), int'(e.d));
                chk("u1 latency", cyc, e.c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        we = 1'b0;
        re = 1'b0;
        clr = 1'b0;
        repeat (n) step();
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] b);
        we = 1'b1; wa = a; di = d; be = b; re = 1'b0;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [15:0] e0, input logic [15:0] e1);
        re = 1'b1; ra = a;
        q0.push_back('{e0, cyc + 1});
        q1.push_back('{e1, cyc + 2});
        step();
        re = 1'b0; we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s u%0d busy", tag, i), int'(busy[i]), 1);
            chk($sformatf("%s u%0d dout", tag, i), int'(dout[i]), 0);
            chk($sformatf("%s u%0d dout_valid", tag, i), int'(dv[i]), 0);
        end
    endtask

    // Counts sampled busy cycles; blocked we/re and a second clr can be injected.
    task automatic measure_busy(input string tag, input bit poke);
        int n0 = 0;
        int n1 = 0;
        int n = 0;
        while ((busy[0] || busy[1]) && n < 2000) begin
            if (busy[0]) n0++;
            if (busy[1]) n1++;
            clr = poke && n == 100;
            we = poke && n >= 10 && n < 20;
            re = we; wa = 10'd10; ra = 10'd10; di = 16'h1234; be = 2'b11;
            step();
            n++;
        end
        idle(0);
        chk($sformatf("%s u0 busy cycles", tag), n0, 512);
        chk($sformatf("%s u1 busy cycles", tag), n1, 512);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        measure_busy("init clear", 1'b0);
        rd(10'd0, 16'h0000, 16'h0000);
        rd(10'd255, 16'h0000, 16'h0000);
        rd(10'd511, 16'h0000, 16'h0000);
        idle(3);
        wr(10'd5, 16'hBEEF, 2'b11);
        wr(10'd5, 16'h1234, 2'b01);
        rd(10'd5, 16'hBE34, 16'hBE34);
        idle(3);
        wr(10'd7, 16'h00AA, 2'b11);
        we = 1'b1; wa = 10'd7; di = 16'h5555; be = 2'b11;
        rd(10'd7, 16'h00AA, 16'h5555);
        rd(10'd7, 16'h5555, 16'h5555);
        idle(3);
        wr(10'd1, 16'h0011, 2'b11);
        wr(10'd2, 16'h0022, 2'b11);
        wr(10'd3, 16'h0033, 2'b11);
        rd(10'd1, 16'h0011, 16'h0011);
        rd(10'd2, 16'h0022, 16'h0022);
        rd(10'd3, 16'h0033, 16'h0033);
        idle(4);
        wr(10'd10, 16'hFFFF, 2'b11);
        rd(10'd10, 16'hFFFF, 16'hFFFF);
        idle(4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        measure_busy("clr", 1'b1);
        rd(10'd10, 16'h0000, 16'h0000);
        idle(3);
        wr(10'd20, 16'hABCD, 2'b11);
        rd(10'd20, 16'hABCD, 16'hABCD);
        idle(4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (200) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-clear reset");
        repeat (2) step();
        rst_n = 1'b1;
        measure_busy("post-reset clear", 1'b0);
        wr(10'd600, 16'h1111, 2'b11);
        rd(10'd600, 16'h1111, 16'h0000);
        rd(10'd88, 16'h1111, 16'h0000);
        idle(5);
        chk("u0 outstanding reads", q0.size(), 0);
        chk("u1 outstanding reads", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
